// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 5;
  localparam int FETCH_DATA_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} fetch entries with push/pop/flush.
// Head outputs come straight from storage registers, so they are stable while the head waits.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W,
  parameter int QDEPTH = 2,
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [DATA_W-1:0] wr_instr,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [ADDR_W-1:0] pc_mem    [QDEPTH];
  logic [DATA_W-1:0] instr_mem [QDEPTH];
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) tail_next = ptr_inc(tail_reg);
      if (pop)  head_next = ptr_inc(head_reg);
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // One storage slot per entry; only the tail slot is written on a push.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pc_mem[gi]    <= '0;
        instr_mem[gi] <= DATA_W'(NOP);
      end else if (push && !flush && tail_reg == PTR_W'(gi)) begin
        pc_mem[gi]    <= wr_pc;
        instr_mem[gi] <= wr_instr;
      end
    end
  end

  assign count      = count_reg;
  assign head_pc    = pc_mem[head_reg];
  assign head_instr = instr_mem[head_reg];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, queues {PC, Instruction} words and hands them to decode.
// Optional FETCH_PERF_EN adds saturating FetchCount/FlushCount outputs.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int DATA_W   = FETCH_DATA_W,
  parameter int QDEPTH   = 2,
  parameter int RESET_PC = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  output logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Instruction,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  output logic              IfValid,
  input  logic              IfReady,
  output logic [DATA_W-1:0] IfInstr,
  output logic [ADDR_W-1:0] IfPC
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       FetchCount,
  output logic [15:0]       FlushCount
`endif
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]  count;
  logic              push, pop;

  assign pop  = IfValid & IfReady;
  // A pop frees a slot this cycle, so a full queue can still accept a push.
  assign push = !Redirect && ((count < CNT_W'(QDEPTH)) || pop);

  always_comb begin
    pc_next = pc_reg;
    if (Redirect)  pc_next = RedirectAddr;
    else if (push) pc_next = pc_reg + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) pc_reg <= ADDR_W'(RESET_PC);
    else        pc_reg <= pc_next;
  end

  assign Address = pc_reg;
  assign IfValid = (count != '0);

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (Redirect),
    .wr_pc      (pc_reg),
    .wr_instr   (Instruction),
    .count      (count),
    .head_pc    (IfPC),
    .head_instr (IfInstr)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_reg, flush_cnt_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (push && fetch_cnt_reg != 16'hFFFF)     fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
      if (Redirect && flush_cnt_reg != 16'hFFFF) flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign FetchCount = fetch_cnt_reg;
  assign FlushCount = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit; memory is a ROM with word i = A000_0000+i.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [4:0]  Address;
  logic [31:0] Instruction;
  logic        Redirect = 1'b0;
  logic [4:0]  RedirectAddr = '0;
  logic        IfValid;
  logic        IfReady = 1'b0;
  logic [31:0] IfInstr;
  logic [4:0]  IfPC;
`ifdef FETCH_PERF_EN
  logic [15:0] FetchCount, FlushCount;
`endif

  int cmp_count = 0;
  int err_count = 0;
  fetch_entry_t sb[$];
  fetch_entry_t exp_e;

  always #5 Clk = ~Clk;

  assign Instruction = 32'hA000_0000 + {27'b0, Address};

  instruction_fetch_unit dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Address      (Address),
    .Instruction  (Instruction),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .IfValid      (IfValid),
    .IfReady      (IfReady),
    .IfInstr      (IfInstr),
    .IfPC         (IfPC)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount   (FetchCount),
    .FlushCount   (FlushCount)
`endif
  );

  function automatic fetch_entry_t rom_entry(input int pc);
    fetch_entry_t e;
    e.pc    = 5'(pc);
    e.instr = 32'hA000_0000 + 32'(pc % 32);
    return e;
  endfunction

  // Stimulus only: hold reset across an edge, then release at a negedge.
  task automatic apply_reset(input logic ready);
    @(negedge Clk);
    Rst_n = 1'b0; Redirect = 1'b0; IfReady = ready;
    @(negedge Clk);
    Rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst_n = 1'b0; IfReady = 1'b1;
    #1;
    cmp_count++;
    if (Address !== 5'd0 || IfValid !== 1'b0 || IfInstr !== 32'h0 || IfPC !== 5'd0) begin
      err_count++;
      $display("FAIL reset_state: got addr=%0d valid=%b instr=%h pc=%0d, want 0/0/0/0",
               Address, IfValid, IfInstr, IfPC);
    end
`ifdef FETCH_PERF_EN
    cmp_count++;
    if (FetchCount !== 16'd0 || FlushCount !== 16'd0) begin
      err_count++;
      $display("FAIL reset_perf: got fetch=%0d flush=%0d, want 0/0", FetchCount, FlushCount);
    end
`endif
    @(negedge Clk);
    Rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(rom_entry(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      exp_e = sb.pop_front();
      cmp_count++;
      if (IfValid !== 1'b1 || IfPC !== exp_e.pc || IfInstr !== exp_e.instr) begin
        err_count++;
        $display("FAIL stream_after_reset: got v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 IfValid, IfPC, IfInstr, exp_e.pc, exp_e.instr);
      end else $display("pop pc=%0d instr=%h", IfPC, IfInstr);
    end
  endtask

  task automatic test_stall();
    apply_reset(1'b0);
    repeat (4) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      cmp_count++;
      if (Address !== 5'd2 || IfValid !== 1'b1 || IfPC !== 5'd0 || IfInstr !== 32'hA000_0000) begin
        err_count++;
        $display("FAIL stall_hold: got addr=%0d v=%b pc=%0d instr=%h, want 2/1/0/a0000000",
                 Address, IfValid, IfPC, IfInstr);
      end else $display("stall addr=%0d pc=%0d", Address, IfPC);
      @(negedge Clk);
    end
    IfReady = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(rom_entry(i));
    for (int i = 0; i < 3; i++) begin
      exp_e = sb.pop_front();
      cmp_count++;
      if (IfValid !== 1'b1 || IfPC !== exp_e.pc || IfInstr !== exp_e.instr) begin
        err_count++;
        $display("FAIL stall_release: got v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 IfValid, IfPC, IfInstr, exp_e.pc, exp_e.instr);
      end else $display("pop pc=%0d instr=%h", IfPC, IfInstr);
      @(negedge Clk);
    end
  endtask

  task automatic test_redirect_full();
    apply_reset(1'b0);
    repeat (3) @(negedge Clk);
    Redirect = 1'b1; RedirectAddr = 5'd17;
    @(negedge Clk);
    Redirect = 1'b0;
    cmp_count++;
    if (IfValid !== 1'b0 || Address !== 5'd17) begin
      err_count++;
      $display("FAIL redirect_flush: got v=%b addr=%0d, want v=0 addr=17", IfValid, Address);
    end else $display("flush addr=%0d", Address);
    sb.push_back(rom_entry(17));
    @(negedge Clk);
    exp_e = sb.pop_front();
    cmp_count++;
    if (IfValid !== 1'b1 || IfPC !== exp_e.pc || IfInstr !== exp_e.instr) begin
      err_count++;
      $display("FAIL redirect_target: got v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
               IfValid, IfPC, IfInstr, exp_e.pc, exp_e.instr);
    end else $display("pop pc=%0d instr=%h", IfPC, IfInstr);
  endtask

  task automatic test_wrap();
    @(negedge Clk);
    IfReady = 1'b1; Redirect = 1'b1; RedirectAddr = 5'd30;
    @(negedge Clk);
    Redirect = 1'b0;
    sb.delete();
    foreach (sb[i]) sb.delete(i);
    sb.push_back(rom_entry(30)); sb.push_back(rom_entry(31));
    sb.push_back(rom_entry(32)); sb.push_back(rom_entry(33));
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      exp_e = sb.pop_front();
      cmp_count++;
      if (IfValid !== 1'b1 || IfPC !== exp_e.pc || IfInstr !== exp_e.instr) begin
        err_count++;
        $display("FAIL wrap: got v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 IfValid, IfPC, IfInstr, exp_e.pc, exp_e.instr);
      end else $display("pop pc=%0d instr=%h", IfPC, IfInstr);
    end
  endtask

  task automatic test_redirect_pop();
    @(negedge Clk);
    IfReady = 1'b1; Redirect = 1'b1; RedirectAddr = 5'd5;
    @(negedge Clk);
    Redirect = 1'b0;
    sb.delete();
    sb.push_back(rom_entry(5)); sb.push_back(rom_entry(6));
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      exp_e = sb.pop_front();
      cmp_count++;
      if (IfValid !== 1'b1 || IfPC !== exp_e.pc || IfInstr !== exp_e.instr) begin
        err_count++;
        $display("FAIL pre_redirect: got v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 IfValid, IfPC, IfInstr, exp_e.pc, exp_e.instr);
      end else $display("pop pc=%0d instr=%h", IfPC, IfInstr);
    end
    // Head 6 is popped on the same edge that redirects to 20.
    Redirect = 1'b1; RedirectAddr = 5'd20;
    @(negedge Clk);
    Redirect = 1'b0;
    cmp_count++;
    if (IfValid !== 1'b0 || Address !== 5'd20) begin
      err_count++;
      $display("FAIL redirect_pop_flush: got v=%b addr=%0d, want v=0 addr=20", IfValid, Address);
    end else $display("flush addr=%0d", Address);
    for (int i = 20; i < 23; i++) sb.push_back(rom_entry(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      exp_e = sb.pop_front();
      cmp_count++;
      if (IfValid !== 1'b1 || IfPC !== exp_e.pc || IfInstr !== exp_e.instr) begin
        err_count++;
        $display("FAIL post_redirect: got v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 IfValid, IfPC, IfInstr, exp_e.pc, exp_e.instr);
      end else $display("pop pc=%0d instr=%h", IfPC, IfInstr);
    end
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    IfReady = 1'b1; Redirect = 1'b1; RedirectAddr = 5'd12;
    @(negedge Clk);
    Redirect = 1'b0;
    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    cmp_count++;
    if (IfValid !== 1'b0 || Address !== 5'd0) begin
      err_count++;
      $display("FAIL async_reset: got v=%b addr=%0d, want v=0 addr=0", IfValid, Address);
    end else $display("async reset addr=%0d", Address);
`ifdef FETCH_PERF_EN
    cmp_count++;
    if (FetchCount !== 16'd0 || FlushCount !== 16'd0) begin
      err_count++;
      $display("FAIL async_reset_perf: got fetch=%0d flush=%0d, want 0/0", FetchCount, FlushCount);
    end
`endif
    @(negedge Clk);
    Rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back(rom_entry(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      exp_e = sb.pop_front();
      cmp_count++;
      if (IfValid !== 1'b1 || IfPC !== exp_e.pc || IfInstr !== exp_e.instr) begin
        err_count++;
        $display("FAIL restart: got v=%b pc=%0d instr=%h, want v=1 pc=%0d instr=%h",
                 IfValid, IfPC, IfInstr, exp_e.pc, exp_e.instr);
      end else $display("pop pc=%0d instr=%h", IfPC, IfInstr);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_redirect_pop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
